mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported program/data RAM between three requesters: program loader (write-only), data-memory stage (read/write) and instruction fetch (read-only).
- Serialises accesses with a registered state machine, hides the RAM's fixed read latency, and returns a one-cycle ack with captured read data to the winner.
- Sits between the stage-sequenced CPU core / loader and the block RAM.

Parameters:
ADDR_W, 15, word-address width of the RAM
DATA_W, 32, data width
RD_LATENCY, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4
STARVE_MAX, 4, consecutive lost arbitrations after which a pending fetch request is given top priority

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
ld_req  in  1  loader write request, held until ld_ack
ld_addr  in  ADDR_W  loader address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  one-cycle completion pulse to loader
dm_req  in  1  data-stage request, held until dm_ack
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  data write data
dm_rdata  out  DATA_W  captured read data, valid while dm_ack = 1 and held afterwards
dm_ack  out  1  one-cycle completion pulse to data stage
im_req  in  1  fetch read request, held until im_ack
im_addr  in  ADDR_W  fetch address
im_rdata  out  DATA_W  captured instruction, valid while im_ack = 1 and held afterwards
im_ack  out  1  one-cycle completion pulse to fetch
mem_en  out  1  RAM enable, registered
mem_we  out  1  RAM write enable, registered
mem_addr  out  ADDR_W  RAM address, registered
mem_wdata  out  DATA_W  RAM write data, registered
mem_rdata  in  DATA_W  RAM read data
busy  out  1  1 when state != IDLE
owner  out  2  current owner: 0 none, 1 ld, 2 dm, 3 im

Behaviour:
- Reset, sampled on posedge clk with reset_n = 0, wins over everything, including mid-transaction. State goes to IDLE. All acks, mem_en, mem_we and busy go to 0; owner = 0; mem_addr, mem_wdata, dm_rdata and im_rdata go to 0; starve counter goes to 0. Any in-flight access is abandoned with no ack.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Each cycle, arbitrate among asserted requests.
  - Priority is ld > dm > im. Exception: if starve_cnt >= STARVE_MAX and im_req = 1, im wins over all.
  - Latch the winner's addr, wdata and we (ld: we = 1; im: we = 0). Set owner and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (exactly one cycle):
  - mem_en = 1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Write: next state DONE.
  - Read: next state WAIT, with the wait counter loaded to RD_LATENCY.
- WAIT:
  - mem_en = 0. Decrement the counter each cycle.
  - In the cycle the counter equals 1, mem_rdata is valid. Capture it into dm_rdata or im_rdata (per owner) and go to DONE.
  - WAIT lasts exactly RD_LATENCY cycles.
- DONE (exactly one cycle):
  - The owner's ack = 1 and all other acks = 0.
  - Next state IDLE, owner = 0.
- Latency, with the request first sampled in IDLE at cycle 0: write ack at cycle 2; read ack at cycle 2 + RD_LATENCY.
- Back-to-back: there is always at least one IDLE cycle between DONE and the next ISSUE. Sustained throughput is one access per 3 cycles (write) or 3 + RD_LATENCY cycles (read).
- Requester rule: req must be deasserted, or represent a new request, in the cycle after its ack.
  - If req drops before ack, the transaction still completes: a write is committed and the ack still pulses.
  - Address and data changes after IDLE sampling are ignored, because the values are latched.
- Starve counter:
  - At each arbitration where im_req = 1 and im loses: increment, saturating at STARVE_MAX.
  - Cleared when im wins, or when im_req = 0 at arbitration.
- Read data registers are updated only on the owner's capture. Otherwise they hold.
- Simultaneous requests: only one is granted per arbitration. Losers stay pending with no ack.
- mem_we is never 1 for an im transaction. mem_en = 1 only in ISSUE.

Test Plan:
- Single dm read at addr 0x0010, RAM returning 0xDEADBEEF, RD_LATENCY = 1 → mem_en pulses at cycle 1; dm_ack at cycle 3 with dm_rdata = 0xDEADBEEF; busy is high for cycles 1–3.
- Single ld write of 0x12345678 to addr 0x0004 → mem_en = mem_we = 1 at cycle 1 with that addr/data; ld_ack at cycle 2; no dm_ack or im_ack.
- ld_req, dm_req and im_req all asserted at cycle 0 and held until acked → grant order ld, dm, im; owner sequence 1, 2, 3; each ack exactly once.
- dm_req held continuously (re-requesting after each ack) while im_req pending, STARVE_MAX = 4 → im is granted at the 5th arbitration; starve counter returns to 0.
- reset_n = 0 during WAIT of an im read → next cycle state is IDLE, im_ack never pulses, im_rdata = 0, all outputs at reset values.
- RD_LATENCY = 3 im read of addr 0x0100 → im_ack exactly 5 cycles after sampling; the captured value equals mem_rdata in the 3rd WAIT cycle, not the 1st or 2nd.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported program/data RAM between loader, data stage and fetch.
// One access at a time; read latency is absorbed in WAIT and the result is returned with a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  input  logic              im_req,
  input  logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_rdata,
  output logic              im_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam int              SW         = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [2:0]      LAT        = 3'(RD_LATENCY);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_LD   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;
  localparam logic [1:0] OWN_IM   = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state;
  logic [2:0]    wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic [1:0]    grant;

  // Fixed priority ld > dm > im, unless fetch has lost too many arbitrations in a row.
  always_comb begin
    grant = OWN_NONE;
    if (im_req && (starve_cnt >= STARVE_LIM)) grant = OWN_IM;
    else if (ld_req)                          grant = OWN_LD;
    else if (dm_req)                          grant = OWN_DM;
    else if (im_req)                          grant = OWN_IM;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      dm_rdata   <= '0;
      im_rdata   <= '0;
      ld_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      im_ack     <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      ld_ack <= 1'b0;
      dm_ack <= 1'b0;
      im_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!im_req || grant == OWN_IM) starve_cnt <= '0;
          else if (starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
          case (grant)
            OWN_LD: begin
              mem_we    <= 1'b1;
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
            end
            OWN_DM: begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end
            OWN_IM: begin
              mem_we   <= 1'b0;
              mem_addr <= im_addr;
            end
            default: ;
          endcase
          if (grant != OWN_NONE) begin
            owner  <= grant;
            mem_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        // The latched write enable decides whether a read latency has to be waited out.
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (mem_we) begin
            ld_ack <= (owner == OWN_LD);
            dm_ack <= (owner == OWN_DM);
            state  <= DONE;
          end else begin
            wait_cnt <= LAT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == 3'd1) begin
            if (owner == OWN_DM) begin
              dm_rdata <= mem_rdata;
              dm_ack   <= 1'b1;
            end
            if (owner == OWN_IM) begin
              im_rdata <= mem_rdata;
              im_ack   <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          owner <= OWN_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
